// File: rtl/rtc_time_counter.sv
// rtc_time_counter: 24-hour binary timekeeping core.
//
// A prescaler divides clk down to a 1 Hz tick that advances seconds, minutes
// and hours (plain binary, no BCD). A validated full-time load and single-step
// hour/minute adjust pulses are accepted from the button logic.
//
// Build option: define RTC_12H_EN to present hour as 1..12 with a pm flag.
// Internal counting, load ranges and inc_hour stay 24-hour either way.
//
// Parameters:
//   CLK_FREQ   system clock cycles per second
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   run_en     1 = time advances, 0 = prescaler and time frozen
//   load       one-cycle request to load load_hour/load_min/load_sec
//   load_hour  load value 0..23
//   load_min   load value 0..59
//   load_sec   load value 0..59
//   inc_hour   one-cycle pulse, hour +1 mod 24
//   inc_min    one-cycle pulse, minute +1 mod 60 (no carry into hour)
//   hour       current hour (0..23, or 1..12 with RTC_12H_EN)
//   min        current minute
//   sec        current second
//   pm         internal hour >= 12 (RTC_12H_EN only, else 0)
//   tick_1hz   one-cycle pulse coincident with each seconds advance
//   load_err   one-cycle pulse when a load is rejected
module rtc_time_counter #(
  parameter int unsigned CLK_FREQ = 27_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       load,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       inc_hour,
  input  logic       inc_min,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       pm,
  output logic       tick_1hz,
  output logic       load_err
);

  localparam int unsigned PrescW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(CLK_FREQ - 1);

`ifdef RTC_12H_EN
  localparam logic [4:0] HourRst = 5'd12;
`else
  localparam logic [4:0] HourRst = 5'd0;
`endif

  logic [PrescW-1:0] presc_q, presc_d;
  logic [4:0]        h24_q, h24_d;
  logic [5:0]        m_q, m_d;
  logic [5:0]        s_q, s_d;
  logic [4:0]        hour_q, hour_d;
  logic              pm_q, pm_d;
  logic              tick_q, tick_d;
  logic              err_q, err_d;
  logic              load_ok;

  assign load_ok = (load_hour <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);

  // Priority: load > inc_* > prescaler. Any inc cycle freezes the prescaler,
  // so a pending terminal count is deferred and never collides with an adjust.
  always_comb begin
    presc_d = presc_q;
    h24_d   = h24_q;
    m_d     = m_q;
    s_d     = s_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (load_ok) begin
        h24_d   = load_hour;
        m_d     = load_min;
        s_d     = load_sec;
        presc_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (inc_hour || inc_min) begin
      if (inc_min) begin
        m_d = (m_q == 6'd59) ? 6'd0 : m_q + 6'd1;
      end
      if (inc_hour) begin
        h24_d = (h24_q == 5'd23) ? 5'd0 : h24_q + 5'd1;
      end
    end else if (run_en) begin
      if (presc_q == PrescMax) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (s_q == 6'd59) begin
          s_d = 6'd0;
          if (m_q == 6'd59) begin
            m_d   = 6'd0;
            h24_d = (h24_q == 5'd23) ? 5'd0 : h24_q + 5'd1;
          end else begin
            m_d = m_q + 6'd1;
          end
        end else begin
          s_d = s_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + PrescW'(1);
      end
    end
  end

  // Display mapping is computed from the next hour so it lands on the same
  // edge as the counters.
  always_comb begin
`ifdef RTC_12H_EN
    if (h24_d == 5'd0) begin
      hour_d = 5'd12;
    end else if (h24_d > 5'd12) begin
      hour_d = h24_d - 5'd12;
    end else begin
      hour_d = h24_d;
    end
    pm_d = (h24_d >= 5'd12);
`else
    hour_d = h24_d;
    pm_d   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      h24_q   <= 5'd0;
      m_q     <= 6'd0;
      s_q     <= 6'd0;
      hour_q  <= HourRst;
      pm_q    <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      h24_q   <= h24_d;
      m_q     <= m_d;
      s_q     <= s_d;
      hour_q  <= hour_d;
      pm_q    <= pm_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign hour     = hour_q;
  assign min      = m_q;
  assign sec      = s_q;
  assign pm       = pm_q;
  assign tick_1hz = tick_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Scoreboard bench for rtc_time_counter with CLK_FREQ = 10. Stimulus pushes
// cycle-stamped expected output snapshots; the monitor pops and compares each
// one on the falling edge of the cycle it is due.
module tb_rtc_time_counter;

  localparam int unsigned ClkFreq = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_en = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_hour = '0;
  logic [5:0] load_min = '0;
  logic [5:0] load_sec = '0;
  logic       inc_hour = 1'b0;
  logic       inc_min = 1'b0;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       pm;
  logic       tick_1hz;
  logic       load_err;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit done = 1'b0;
  bit final_checked = 1'b0;

  typedef struct packed {
    int         c;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       pm;
    logic       tk;
    logic       er;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  exp_t  mon_e;
  string mon_n;

  rtc_time_counter #(
    .CLK_FREQ(ClkFreq)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run_en   (run_en),
    .load     (load),
    .load_hour(load_hour),
    .load_min (load_min),
    .load_sec (load_sec),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .hour     (hour),
    .min      (min),
    .sec      (sec),
    .pm       (pm),
    .tick_1hz (tick_1hz),
    .load_err (load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] exp_hr(input int h);
`ifdef RTC_12H_EN
    return (h % 12 == 0) ? 5'd12 : 5'(h % 12);
`else
    return 5'(h);
`endif
  endfunction

  function automatic logic exp_pm(input int h);
`ifdef RTC_12H_EN
    return (h >= 12);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: compare every snapshot due at or before this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      mon_e = q.pop_front();
      mon_n = qn.pop_front();
      n_tests++;
      if (mon_e.c != cyc ||
          {hour, min, sec, pm, tick_1hz, load_err} !==
          {mon_e.h, mon_e.m, mon_e.s, mon_e.pm, mon_e.tk, mon_e.er}) begin
        n_fail++;
        $display("FAIL %s cyc=%0d due=%0d: got %0d:%0d:%0d pm=%0b tick=%0b err=%0b, want %0d:%0d:%0d pm=%0b tick=%0b err=%0b",
                 mon_n, cyc, mon_e.c, hour, min, sec, pm, tick_1hz, load_err,
                 mon_e.h, mon_e.m, mon_e.s, mon_e.pm, mon_e.tk, mon_e.er);
      end
    end
    if (done && !final_checked) begin
      n_tests++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: %0d expectations never checked, want 0", q.size());
      end
      final_checked = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic exp_at(input string nm, input int c, input int h, input int m, input int s,
                        input bit tk, input bit er);
    exp_t e;
    e.c  = c;
    e.h  = exp_hr(h);
    e.m  = 6'(m);
    e.s  = 6'(s);
    e.pm = exp_pm(h);
    e.tk = tk;
    e.er = er;
    q.push_back(e);
    qn.push_back(nm);
  endtask

  // Returns with cyc equal to the edge that sampled the load.
  task automatic do_load(input int h, input int m, input int s);
    load      = 1'b1;
    load_hour = 5'(h);
    load_min  = 6'(m);
    load_sec  = 6'(s);
    step();
    load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b;
    int t;
    rst = 1'b1;
    step();
    step();
    exp_at("reset", cyc, 0, 0, 0, 0, 0);

    // Free run from reset: tick every 10 cycles.
    rst    = 1'b0;
    run_en = 1'b1;
    b      = cyc;
    exp_at("pre_tick1", b + 9, 0, 0, 0, 0, 0);
    exp_at("tick1", b + 10, 0, 0, 1, 1, 0);
    exp_at("post_tick1", b + 11, 0, 0, 1, 0, 0);
    exp_at("tick2", b + 20, 0, 0, 2, 1, 0);
    exp_at("tick3", b + 30, 0, 0, 3, 1, 0);
    wait_cyc(b + 30);

    // Midnight rollover.
    do_load(23, 59, 58);
    t = cyc;
    exp_at("load_235958", t, 23, 59, 58, 0, 0);
    exp_at("pre_sec59", t + 9, 23, 59, 58, 0, 0);
    exp_at("sec59", t + 10, 23, 59, 59, 1, 0);
    exp_at("pre_midnight", t + 19, 23, 59, 59, 0, 0);
    exp_at("midnight", t + 20, 0, 0, 0, 1, 0);
    wait_cyc(t + 20);

    // Rejected loads hold time and prescaler.
    do_load(24, 0, 0);
    t = cyc;
    exp_at("err_hour", t, 0, 0, 0, 0, 1);
    exp_at("err_hour_clear", t + 1, 0, 0, 0, 0, 0);
    step();
    do_load(12, 60, 0);
    exp_at("err_min", t + 2, 0, 0, 0, 0, 1);
    exp_at("err_min_clear", t + 3, 0, 0, 0, 0, 0);
    exp_at("pre_held_tick", t + 10, 0, 0, 0, 0, 0);
    exp_at("held_tick", t + 11, 0, 0, 1, 1, 0);
    wait_cyc(t + 11);

    // inc_min at terminal count: no carry, tick deferred one cycle.
    do_load(10, 59, 30);
    t = cyc;
    exp_at("load_105930", t, 10, 59, 30, 0, 0);
    wait_cyc(t + 9);
    inc_min = 1'b1;
    step();
    inc_min = 1'b0;
    exp_at("inc_min_wrap", t + 10, 10, 0, 30, 0, 0);
    exp_at("deferred_tick", t + 11, 10, 0, 31, 1, 0);
    exp_at("next_tick", t + 21, 10, 0, 32, 1, 0);
    wait_cyc(t + 21);

    // Both incs together, with wraps.
    do_load(23, 59, 0);
    t = cyc;
    exp_at("load_2359", t, 23, 59, 0, 0, 0);
    inc_hour = 1'b1;
    inc_min  = 1'b1;
    step();
    inc_hour = 1'b0;
    inc_min  = 1'b0;
    exp_at("inc_both_wrap", t + 1, 0, 0, 0, 0, 0);
    exp_at("tick_after_inc", t + 11, 0, 0, 1, 1, 0);

    // Freeze 25 cycles mid-second.
    wait_cyc(t + 15);
    run_en = 1'b0;
    exp_at("frozen_nominal", t + 21, 0, 0, 1, 0, 0);
    wait_cyc(t + 40);
    run_en = 1'b1;
    exp_at("pre_late_tick", t + 45, 0, 0, 1, 0, 0);
    exp_at("late_by_25", t + 46, 0, 0, 2, 1, 0);
    wait_cyc(t + 46);

    // Load while frozen takes effect immediately.
    run_en = 1'b0;
    step();
    step();
    do_load(5, 6, 7);
    t = cyc;
    exp_at("load_frozen", t, 5, 6, 7, 0, 0);
    exp_at("still_frozen", t + 5, 5, 6, 7, 0, 0);
    wait_cyc(t + 5);
    run_en = 1'b1;
    exp_at("pre_resume_tick", t + 14, 5, 6, 7, 0, 0);
    exp_at("resume_tick", t + 15, 5, 6, 8, 1, 0);
    wait_cyc(t + 15);

    // Hour display mapping.
    run_en = 1'b0;
    do_load(0, 0, 0);
    exp_at("hour_00", cyc, 0, 0, 0, 0, 0);
    do_load(13, 0, 0);
    exp_at("hour_13", cyc, 13, 0, 0, 0, 0);
    do_load(12, 0, 0);
    exp_at("hour_12", cyc, 12, 0, 0, 0, 0);

    // Seconds-to-minute-to-hour carry.
    run_en = 1'b1;
    do_load(9, 59, 59);
    t = cyc;
    exp_at("carry_10h", t + 10, 10, 0, 0, 1, 0);
    wait_cyc(t + 12);
    do_load(0, 0, 60);
    exp_at("err_sec", cyc, 10, 0, 0, 0, 1);

    // Reset wins over a same-cycle load.
    step();
    rst       = 1'b1;
    load      = 1'b1;
    load_hour = 5'd5;
    load_min  = 6'd6;
    load_sec  = 6'd7;
    step();
    rst  = 1'b0;
    load = 1'b0;
    t    = cyc;
    exp_at("rst_drops_load", t, 0, 0, 0, 0, 0);
    exp_at("tick_after_rst", t + 10, 0, 0, 1, 1, 0);
    wait_cyc(t + 11);

    done = 1'b1;
    for (int i = 0; i < 5 && !final_checked; i++) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
